// File: rtl/z80_bus_mem.sv
// z80_bus_mem: memory bus slave for the Z80 CPU bench.
// Decodes MREQ/RD/WR/M1/RFSH, inserts programmable wait states, serves
// reads from a mirrored RAM image, guards a low ROM window against writes
// and provides a preload port for the bench.
module z80_bus_mem #(
    parameter int MEM_AW      = 12,
    parameter int WAIT_STATES = 1,
    parameter int M1_WAITS    = 0,
    parameter int ROM_TOP     = 'h0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              M1,
    input  logic              MREQ,
    input  logic              RD,
    input  logic              WR,
    input  logic              RFSH,
    input  logic [15:0]       ADDRESS_BUS,
    input  logic [7:0]        DATA_BUS_O,
    output logic [7:0]        DATA_BUS_I,
    output logic              WAIT_N,
    input  logic              LOAD_EN,
    input  logic [MEM_AW-1:0] LOAD_ADDR,
    input  logic [7:0]        LOAD_DATA,
    output logic              BUS_ERR
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_t;

    localparam logic [3:0]      WS_CNT  = 4'(WAIT_STATES);
    localparam logic [3:0]      M1_CNT  = 4'(M1_WAITS);
    localparam logic [MEM_AW:0] ROM_LIM = (MEM_AW+1)'(ROM_TOP);

    logic [7:0]        mem [0:(1<<MEM_AW)-1];
    state_t            state;
    logic [MEM_AW-1:0] addr_q;
    logic              op_wr;
    logic              op_bad;
    logic [3:0]        cnt;

    logic              req;
    logic [3:0]        n_sel;
    logic              load_ok;
    logic              rom_hit;
    logic              commit_wr;

    // Upper address bits are deliberately ignored so the image mirrors.
    wire [15:0] unused_addr = ADDRESS_BUS;

    assign req       = MREQ & (RD | WR) & ~RFSH;
    assign n_sel     = M1 ? M1_CNT : WS_CNT;
    assign load_ok   = LOAD_EN & (state == IDLE) & ~MREQ;
    assign rom_hit   = {1'b0, addr_q} < ROM_LIM;
    assign commit_wr = (state == ACCESS) & op_wr & ~op_bad & ~rom_hit;

    // RAM array: bench preload or committed CPU write (never both, load needs IDLE).
    always_ff @(posedge CLK) begin
        if (load_ok)
            mem[LOAD_ADDR] <= LOAD_DATA;
        else if (commit_wr)
            mem[addr_q] <= DATA_BUS_O;
    end

    // Bus cycle FSM with registered WAIT_N, read data and error pulse.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            WAIT_N     <= 1'b1;
            DATA_BUS_I <= 8'h00;
            BUS_ERR    <= 1'b0;
            cnt        <= 4'd0;
            addr_q     <= '0;
            op_wr      <= 1'b0;
            op_bad     <= 1'b0;
        end else begin
            BUS_ERR <= LOAD_EN & ~load_ok;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= ADDRESS_BUS[MEM_AW-1:0];
                        op_wr  <= WR;
                        op_bad <= RD & WR;
                        if (n_sel == 4'd0) begin
                            state <= ACCESS;
                        end else begin
                            cnt    <= n_sel;
                            WAIT_N <= 1'b0;
                            state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        WAIT_N <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (op_bad) begin
                        DATA_BUS_I <= 8'hFF;
                        BUS_ERR    <= 1'b1;
                    end else if (op_wr) begin
                        if (rom_hit)
                            BUS_ERR <= 1'b1;
                    end else begin
                        DATA_BUS_I <= mem[addr_q];
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (!MREQ)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_mem.sv
// tb_z80_bus_mem: directed bench for z80_bus_mem with a read-data scoreboard
// and a bench-side memory model that tracks every write it expects to land.
module tb_z80_bus_mem;

    localparam int MEM_AW  = 12;
    localparam int WS      = 3;
    localparam int M1W     = 0;
    localparam int ROM_TOP = 'h100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              m1 = 1'b0, mreq = 1'b0, rd = 1'b0, wr = 1'b0, rfsh = 1'b0;
    logic [15:0]       addr = 16'h0;
    logic [7:0]        dout = 8'h0;
    logic [7:0]        din;
    logic              wait_n;
    logic              load_en = 1'b0;
    logic [MEM_AW-1:0] load_addr = '0;
    logic [7:0]        load_data = 8'h0;
    logic              bus_err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model [0:(1<<MEM_AW)-1];
    logic [7:0]  exp_q [$];
    logic [7:0]  last_rd = 8'h00;

    z80_bus_mem #(
        .MEM_AW(MEM_AW), .WAIT_STATES(WS), .M1_WAITS(M1W), .ROM_TOP(ROM_TOP)
    ) dut (
        .CLK(clk), .RESET(rst_n), .M1(m1), .MREQ(mreq), .RD(rd), .WR(wr),
        .RFSH(rfsh), .ADDRESS_BUS(addr), .DATA_BUS_O(dout), .DATA_BUS_I(din),
        .WAIT_N(wait_n), .LOAD_EN(load_en), .LOAD_ADDR(load_addr),
        .LOAD_DATA(load_data), .BUS_ERR(bus_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s_m1, input logic s_mreq, input logic s_rd,
                                 input logic s_wr, input logic s_rfsh,
                                 input logic [15:0] s_addr, input logic [7:0] s_dout);
        m1 = s_m1; mreq = s_mreq; rd = s_rd; wr = s_wr; rfsh = s_rfsh;
        addr = s_addr; dout = s_dout;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [MEM_AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        model[a] = d;
        checkOutput("preload_no_err", {31'b0, bus_err}, 32'd0);
    endtask

    // One full bus cycle. Request is driven at a negedge; sample i is taken
    // at the negedge after the i-th following posedge, so read data must be
    // present at sample n+1 (n+2 edges after the request is presented).
    task automatic busCycle(input string tag, input logic c_m1, input logic c_rd,
                            input logic c_wr, input logic [15:0] a, input logic [7:0] d,
                            input int exp_err);
        int n;
        int low;
        int errs;
        logic [MEM_AW-1:0] ma;
        logic [7:0] e;
        n    = c_m1 ? M1W : WS;
        low  = 0;
        errs = 0;
        ma   = a[MEM_AW-1:0];
        @(negedge clk);
        applyStimulus(c_m1, 1'b1, c_rd, c_wr, 1'b0, a, d);
        if (c_rd && c_wr) exp_q.push_back(8'hFF);
        else if (c_rd)    exp_q.push_back(model[ma]);
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (!wait_n) low++;
            if (bus_err) errs++;
            if (i == n + 1 && c_rd) begin
                e = exp_q.pop_front();
                last_rd = e;
                checkOutput({tag, "_data"}, {24'b0, din}, {24'b0, e});
            end
        end
        checkOutput({tag, "_wait_cycles"}, low, n);
        checkOutput({tag, "_wait_released"}, {31'b0, wait_n}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk);
        if (bus_err) errs++;
        @(negedge clk);
        if (bus_err) errs++;
        checkOutput({tag, "_bus_err"}, errs, exp_err);
        if (c_wr && !c_rd && ({1'b0, ma} >= (MEM_AW+1)'(ROM_TOP)))
            model[ma] = d;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_wait_n", {31'b0, wait_n}, 32'd1);
        checkOutput("reset_data", {24'b0, din}, 32'h00);
        checkOutput("reset_bus_err", {31'b0, bus_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        preload(12'h010, 8'h3E);
        preload(12'h080, 8'h11);
        preload(12'h123, 8'h77);
        preload(12'h300, 8'h42);
        preload(12'h400, 8'hC3);
        preload(12'h500, 8'h5A);

        $display("[TB] opcode fetch with no wait states");
        busCycle("m1_read", 1'b1, 1'b1, 1'b0, 16'h0010, 8'h00, 0);

        $display("[TB] write/read-back with wait states");
        busCycle("write_200", 1'b0, 1'b0, 1'b1, 16'h0200, 8'hA5, 0);
        busCycle("read_200", 1'b0, 1'b1, 1'b0, 16'h0200, 8'h00, 0);

        $display("[TB] ROM window write");
        busCycle("rom_write", 1'b0, 1'b0, 1'b1, 16'h0080, 8'h55, 1);
        busCycle("rom_readback", 1'b1, 1'b1, 1'b0, 16'h0080, 8'h00, 0);

        $display("[TB] refresh cycle is ignored");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rfsh_wait_n", {31'b0, wait_n}, 32'd1);
        end
        checkOutput("rfsh_data_held", {24'b0, din}, {24'b0, last_rd});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);

        $display("[TB] mirrored address");
        busCycle("mirror_read", 1'b0, 1'b1, 1'b0, 16'hF123, 8'h00, 0);

        $display("[TB] reset during wait states of a write");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0400, 8'h99);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midreset_waiting", {31'b0, wait_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_wait_n", {31'b0, wait_n}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busCycle("midreset_readback", 1'b1, 1'b1, 1'b0, 16'h0400, 8'h00, 0);

        $display("[TB] RD and WR together");
        busCycle("rdwr_conflict", 1'b0, 1'b1, 1'b1, 16'h0300, 8'h13, 1);
        busCycle("rdwr_no_write", 1'b1, 1'b1, 1'b0, 16'h0300, 8'h00, 0);

        $display("[TB] preload while MREQ is high");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        load_en = 1'b1; load_addr = 12'h500; load_data = 8'h66;
        @(negedge clk);
        checkOutput("load_drop_err", {31'b0, bus_err}, 32'd1);
        load_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
        @(negedge clk);
        checkOutput("load_drop_err_end", {31'b0, bus_err}, 32'd0);
        busCycle("load_drop_readback", 1'b0, 1'b1, 1'b0, 16'h0500, 8'h00, 0);

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
